xbar_demux_arb: RTL
===================

# xbar_demux_arb

Round-robin arbiter that shares one demux-bus slave port among `NUM_MASTERS` demux-bus master ports inside the cluster interconnect. It tracks outstanding transactions in an in-order ID FIFO, so every `r_valid`/`r_rdata` response returns to the master that issued the request. It sits between core-side demux ports and a shared peripheral or TCDM-side target.

## Interface
- `NUM_MASTERS`, 4, number of requesting ports (≥2)
- `MAX_OUTSTANDING`, 4, ID FIFO depth (power of two, ≥2)
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `m_req_i / m_add_i / m_we_i / m_wdata_i / m_be_i`  in  N / N×32 / N / N×32 / N×4  per-master request
- `m_barrier_i / m_exec_cancel_i / m_exec_stall_i`  in  N each  per-master sideband
- `m_r_gnt_i`  in  N  per-master response accept
- `m_gnt_o / m_r_valid_o`  out  N each  per-master grant / response valid
- `m_r_rdata_o`  out  N×32  per-master response data
- `m_busy_o`  out  N  busy, broadcast
- `s_req_o / s_add_o / s_we_o / s_wdata_o / s_be_o`  out  1/32/1/32/4  slave request
- `s_barrier_o / s_exec_cancel_o / s_exec_stall_o / s_r_gnt_o`  out  1 each  slave sideband
- `s_gnt_i / s_r_valid_i / s_busy_i`  in  1 each  slave handshake
- `s_r_rdata_i`  in  32  slave response data
- `err_o`  out  1  sticky protocol error flag

## Operation
- **Winner selection.** Winner = first requesting master at or after `rr_ptr`, wrapping modulo N.
- **Request path (combinational).** The winner's `add/we/wdata/be/exec_cancel/exec_stall` drive `s_*`.
  - `s_req_o = |m_req_i & !fifo_full & !barrier_hold`.
  - When `s_req_o` is low, all `s_*` request fields are driven to 0.
- **Grant.** `m_gnt_o[winner] = s_gnt_i & s_req_o`. All other grants are 0.
- **Accepted request** (`s_req_o & s_gnt_i`):
  - Push the winner index into the ID FIFO.
  - Set `rr_ptr` to `(winner+1) mod N`.
- **Response routing.**
  - `head` = FIFO head ID.
  - `m_r_valid_o[head] = s_r_valid_i & !fifo_empty`.
  - `m_r_rdata_o[head] = s_r_rdata_i`. All other ports read 0.
  - `s_r_gnt_o = m_r_gnt_i[head]` when the FIFO is non-empty, else 1.
  - Pop the FIFO on `s_r_valid_i & s_r_gnt_o & !fifo_empty`.
- **Barrier.** `barrier_hold` is set when the winner asserts `m_barrier_i` and its request is accepted. It blocks new requests until the FIFO drains to empty, then clears.
  - `s_barrier_o` = winner's `m_barrier_i` gated by `s_req_o`.
- **Busy.** `m_busy_o[i] = s_busy_i | !fifo_empty` for every i.
- **Error.** `s_r_valid_i` with the FIFO empty sets `err_o`. It is cleared only by reset, and the response is dropped.
- **State** is limited to `rr_ptr`, the FIFO (wptr, rptr, count), `barrier_hold` and `err_o`.

## Timing
- **Reset values.**
  - `rr_ptr`=0, FIFO empty, `barrier_hold`=0, `err_o`=0.
  - Therefore all `m_gnt_o`, `m_r_valid_o` and `s_req_o` are 0, and `m_busy_o = s_busy_i`.
- **Latency.** The request and response paths add zero cycles: the bus is purely combinational through the arbiter. State updates on the rising `clk` edge.
- **Full FIFO.** When `count == MAX_OUTSTANDING`, `s_req_o` is 0 even if a pop happens in the same cycle. There is no `r_valid`→`gnt` combinational path.
- **Simultaneous push and pop** (not full): count is unchanged; both pointers advance and wrap modulo depth.
- **Pointer stability.** `rr_ptr` changes only on an accepted request. Requests stalled by a low `s_gnt_i` keep the same winner, because the winner holds its request.
- **Reset mid-transaction.** Asserting `rst_n` low discards outstanding IDs immediately, asynchronously.

## Structure
- Package `xbar_demux_arb_pkg`:
  - constant `XBAR_DEMUX_DATA_W`=32
  - constant `XBAR_DEMUX_BE_W`=4
  - function `id_width(n)` = `$clog2(n)`, minimum 1
- Sub-module `xbar_demux_arb_idfifo` (parameters: ID width, depth):
  - ports: push, pop, data in, head out, full, empty
  - asynchronous active-low reset

## Test plan
- **Round robin.** N=4, all four masters request continuously, `s_gnt_i`=1, responses returned each cycle → grants issued to 0,1,2,3,0; each response reaches the correct master.
- **FIFO full.** `MAX_OUTSTANDING`=4, `s_r_valid_i` held 0 → 4 grants, then `s_req_o`=0. One response pops FIFO → next cycle one more grant.
- **Out-of-turn routing.** Master 2 issues a read, then master 0. Slave returns `0xDEADBEEF` then `0x12345678` → master 2 gets `0xDEADBEEF`, master 0 gets `0x12345678`.
- **Barrier.** Master 1 issues 2 requests, then a barrier request → no further grants until both responses plus the barrier response pop; the grant to master 3 follows in the next cycle.
- **Backpressure.** `m_r_gnt_i[head]`=0 with `s_r_valid_i`=1 → `s_r_gnt_o`=0 and FIFO count unchanged for 3 cycles; pop on the first cycle `r_gnt` rises.
- **Error and reset.** `s_r_valid_i` with the FIFO empty → `err_o`=1 and stays 1. Reset asserted with 3 outstanding → count=0, `err_o`=0, all grants 0.

Source files
------------

// File: rtl/xbar_demux_arb_pkg.sv
// Shared constants and helpers for the demux-bus round-robin arbiter.
package xbar_demux_arb_pkg;

    localparam int unsigned XBAR_DEMUX_DATA_W = 32;
    localparam int unsigned XBAR_DEMUX_BE_W   = 4;

    // Master ID width; a single-bit ID is kept even for tiny configurations.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xbar_demux_arb_idfifo.sv
// In-order FIFO of master IDs for outstanding transactions.
module xbar_demux_arb_idfifo #(
    parameter int unsigned IdW   = 2,
    parameter int unsigned Depth = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [IdW-1:0] data_i,
    output logic [IdW-1:0] head_o,
    output logic           full_o,
    output logic           empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [IdW-1:0]  mem_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push_ok, pop_ok;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xbar_demux_arb.sv
// Round-robin arbiter sharing one demux-bus slave among several masters, with
// in-order response routing through an ID FIFO.
module xbar_demux_arb
    import xbar_demux_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_MASTERS-1:0]                        m_req_i,
    input  logic [NUM_MASTERS-1:0][XBAR_DEMUX_DATA_W-1:0] m_add_i,
    input  logic [NUM_MASTERS-1:0]                        m_we_i,
    input  logic [NUM_MASTERS-1:0][XBAR_DEMUX_DATA_W-1:0] m_wdata_i,
    input  logic [NUM_MASTERS-1:0][XBAR_DEMUX_BE_W-1:0]   m_be_i,
    input  logic [NUM_MASTERS-1:0]                        m_barrier_i,
    input  logic [NUM_MASTERS-1:0]                        m_exec_cancel_i,
    input  logic [NUM_MASTERS-1:0]                        m_exec_stall_i,
    input  logic [NUM_MASTERS-1:0]                        m_r_gnt_i,
    output logic [NUM_MASTERS-1:0]                        m_gnt_o,
    output logic [NUM_MASTERS-1:0]                        m_r_valid_o,
    output logic [NUM_MASTERS-1:0][XBAR_DEMUX_DATA_W-1:0] m_r_rdata_o,
    output logic [NUM_MASTERS-1:0]                        m_busy_o,
    output logic                                          s_req_o,
    output logic [XBAR_DEMUX_DATA_W-1:0]                  s_add_o,
    output logic                                          s_we_o,
    output logic [XBAR_DEMUX_DATA_W-1:0]                  s_wdata_o,
    output logic [XBAR_DEMUX_BE_W-1:0]                    s_be_o,
    output logic                                          s_barrier_o,
    output logic                                          s_exec_cancel_o,
    output logic                                          s_exec_stall_o,
    output logic                                          s_r_gnt_o,
    input  logic                                          s_gnt_i,
    input  logic                                          s_r_valid_i,
    input  logic                                          s_busy_i,
    input  logic [XBAR_DEMUX_DATA_W-1:0]                  s_r_rdata_i,
    output logic                                          err_o
);

    localparam int unsigned IdW = id_width(NUM_MASTERS);

    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic           barrier_hold_q, barrier_hold_d;
    logic           err_q, err_d;
    logic [IdW-1:0] winner, head;
    logic           found, fifo_full, fifo_empty, accept, pop, barrier_block;
    int unsigned    idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < int'(NUM_MASTERS); k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
            if (!found && m_req_i[idx]) begin
                found  = 1'b1;
                winner = IdW'(idx);
            end
        end
    end

    // The hold only blocks while older transactions are still outstanding.
    assign barrier_block = barrier_hold_q & ~fifo_empty;
    assign s_req_o       = (|m_req_i) & ~fifo_full & ~barrier_block;
    assign accept        = s_req_o & s_gnt_i;
    assign s_r_gnt_o     = fifo_empty ? 1'b1 : m_r_gnt_i[head];
    assign pop           = s_r_valid_i & s_r_gnt_o & ~fifo_empty;
    assign m_busy_o      = {NUM_MASTERS{s_busy_i | ~fifo_empty}};
    assign err_o         = err_q;

    always_comb begin
        s_add_o         = '0;
        s_we_o          = 1'b0;
        s_wdata_o       = '0;
        s_be_o          = '0;
        s_barrier_o     = 1'b0;
        s_exec_cancel_o = 1'b0;
        s_exec_stall_o  = 1'b0;
        m_gnt_o         = '0;
        if (s_req_o) begin
            s_add_o          = m_add_i[winner];
            s_we_o           = m_we_i[winner];
            s_wdata_o        = m_wdata_i[winner];
            s_be_o           = m_be_i[winner];
            s_barrier_o      = m_barrier_i[winner];
            s_exec_cancel_o  = m_exec_cancel_i[winner];
            s_exec_stall_o   = m_exec_stall_i[winner];
            m_gnt_o[winner]  = s_gnt_i;
        end
    end

    always_comb begin
        m_r_valid_o       = '0;
        m_r_rdata_o       = '0;
        m_r_valid_o[head] = s_r_valid_i & ~fifo_empty;
        m_r_rdata_o[head] = s_r_rdata_i;
    end

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        barrier_hold_d = barrier_hold_q;
        err_d          = err_q | (s_r_valid_i & fifo_empty);
        if (accept) begin
            rr_ptr_d = (int'(winner) == int'(NUM_MASTERS) - 1) ? '0 : winner + 1'b1;
        end
        if (accept && m_barrier_i[winner]) begin
            barrier_hold_d = 1'b1;
        end else if (barrier_hold_q && fifo_empty) begin
            barrier_hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            barrier_hold_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            barrier_hold_q <= barrier_hold_d;
            err_q          <= err_d;
        end
    end

    xbar_demux_arb_idfifo #(
        .IdW   (IdW),
        .Depth (MAX_OUTSTANDING)
    ) u_idfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .pop_i   (pop),
        .data_i  (winner),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
